// File: rtl/i2c_ring_sequencer_pkg.sv
// Shared definitions for the I2C ring sequencer: opcodes, FSM states and
// the bit layout of TX command words and RX result words.
package i2c_ring_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_STOP  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_HALT
  } state_e;

  localparam int unsigned CMD_WDATA_LSB = 0;
  localparam int unsigned CMD_OP_LSB    = 8;
  localparam int unsigned CMD_START_BIT = 10;
  localparam int unsigned CMD_ACK_BIT   = 11;
  localparam int unsigned CMD_W         = 12;

  localparam int unsigned RES_RDATA_LSB = 0;
  localparam int unsigned RES_NACK_BIT  = 8;
  localparam int unsigned RES_ARB_BIT   = 9;
  localparam int unsigned RES_BAD_BIT   = 10;
  localparam int unsigned RES_IDX_LSB   = 16;

endpackage

// File: rtl/i2c_ring_sequencer.sv
// Pulls I2C byte commands from a TX ring, runs each through an external byte
// engine and pushes a status word per command into an RX ring.
module i2c_ring_sequencer
  import i2c_ring_sequencer_pkg::*;
#(
  parameter int unsigned RING_AW = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               enable_i,
  input  logic [RING_AW-1:0] tx_wp_i,
  output logic [RING_AW-1:0] tx_rp_o,
  output logic [RING_AW-1:0] tx_raddr_o,
  input  logic [DATA_W-1:0]  tx_rdata_i,
  input  logic [RING_AW-1:0] rx_rp_i,
  output logic [RING_AW-1:0] rx_wp_o,
  output logic [RING_AW-1:0] rx_waddr_o,
  output logic [DATA_W-1:0]  rx_wdata_o,
  output logic               rx_wen_o,
  output logic               eng_valid_o,
  input  logic               eng_ready_i,
  output logic [1:0]         eng_op_o,
  output logic               eng_start_o,
  output logic               eng_ack_o,
  output logic [7:0]         eng_wdata_o,
  input  logic               eng_done_i,
  input  logic [7:0]         eng_rdata_i,
  input  logic               eng_nack_i,
  input  logic               eng_arb_lost_i,
  output logic               busy_o,
  output logic               halted_o
);

  state_e             state_q, state_d;
  logic [RING_AW-1:0] tx_rp_q, rx_wp_q;
  logic [CMD_W-1:0]   cmd_q;
  logic [7:0]         rdata_q;
  logic               nack_q, arb_q, bad_q;
  logic               rx_full, push;
  op_e                dec_op, cmd_op;
  logic               unused_hi;

  assign unused_hi = ^tx_rdata_i[DATA_W-1:CMD_W];

  // The routing decision in DECODE must come from the live read data, since
  // the command register only holds it from the following cycle on.
  assign dec_op  = op_e'(tx_rdata_i[CMD_OP_LSB +: 2]);
  assign cmd_op  = op_e'(cmd_q[CMD_OP_LSB +: 2]);
  assign rx_full = (rx_wp_q + RING_AW'(1)) == rx_rp_i;
  assign push    = (state_q == ST_PUSH) && !rx_full;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (enable_i && (tx_rp_q != tx_wp_i)) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (dec_op == OP_RSVD) ? ST_PUSH : ST_ISSUE;
      ST_ISSUE:  if (eng_ready_i) state_d = ST_WAIT;
      ST_WAIT:   if (eng_done_i) state_d = ST_PUSH;
      ST_PUSH:   if (!rx_full) state_d = arb_q ? ST_HALT : ST_IDLE;
      ST_HALT:   if (!enable_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      arb_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        cmd_q   <= tx_rdata_i[CMD_W-1:0];
        rdata_q <= '0;
        nack_q  <= 1'b0;
        arb_q   <= 1'b0;
        bad_q   <= (dec_op == OP_RSVD);
      end
      if ((state_q == ST_WAIT) && eng_done_i) begin
        rdata_q <= (cmd_op == OP_READ) ? eng_rdata_i : '0;
        nack_q  <= eng_nack_i;
        arb_q   <= eng_arb_lost_i;
      end
      if (push) begin
        tx_rp_q <= tx_rp_q + RING_AW'(1);
        rx_wp_q <= rx_wp_q + RING_AW'(1);
      end
    end
  end

  always_comb begin
    rx_wdata_o                         = '0;
    rx_wdata_o[RES_RDATA_LSB +: 8]     = rdata_q;
    rx_wdata_o[RES_NACK_BIT]           = nack_q;
    rx_wdata_o[RES_ARB_BIT]            = arb_q;
    rx_wdata_o[RES_BAD_BIT]            = bad_q;
    rx_wdata_o[RES_IDX_LSB +: 8]       = 8'(tx_rp_q);
  end

  assign tx_rp_o     = tx_rp_q;
  assign tx_raddr_o  = tx_rp_q;
  assign rx_wp_o     = rx_wp_q;
  assign rx_waddr_o  = rx_wp_q;
  assign rx_wen_o    = push;
  assign eng_valid_o = (state_q == ST_ISSUE);
  assign eng_op_o    = cmd_q[CMD_OP_LSB +: 2];
  assign eng_start_o = cmd_q[CMD_START_BIT];
  assign eng_ack_o   = cmd_q[CMD_ACK_BIT];
  assign eng_wdata_o = cmd_q[CMD_WDATA_LSB +: 8];
  assign busy_o      = (state_q != ST_IDLE);
  assign halted_o    = (state_q == ST_HALT);

endmodule

// File: tb/tb_i2c_ring_sequencer.sv
// Directed self-checking bench for i2c_ring_sequencer with a TX ring memory,
// an always-ready byte-engine responder and an RX write log.
module tb_i2c_ring_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  tx_wp = '0, rx_rp = '0;
  logic [7:0]  tx_rp, tx_raddr, rx_wp, rx_waddr;
  logic [31:0] tx_rdata = '0;
  logic [31:0] rx_wdata;
  logic        rx_wen, eng_valid, eng_ready, eng_start, eng_ack;
  logic        eng_done = 1'b0;
  logic        eng_nack, eng_arb, busy, halted;
  logic [1:0]  eng_op;
  logic [7:0]  eng_wdata, eng_rdata;

  logic [7:0]  resp_rdata = '0;
  logic        resp_nack = 1'b0, resp_arb = 1'b0, hold_done = 1'b0;
  logic [31:0] txmem [256];

  int n_checks = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int valid_cyc = 0;
  int wr_count = 0;
  logic [1:0]  last_op = '0;
  logic        last_start = 1'b0, last_ack = 1'b0;
  logic [7:0]  last_wdata = '0;
  logic [7:0]  log_addr [$];
  logic [31:0] log_data [$];

  i2c_ring_sequencer #(.RING_AW(8), .DATA_W(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .enable_i(enable),
    .tx_wp_i(tx_wp), .tx_rp_o(tx_rp), .tx_raddr_o(tx_raddr), .tx_rdata_i(tx_rdata),
    .rx_rp_i(rx_rp), .rx_wp_o(rx_wp), .rx_waddr_o(rx_waddr), .rx_wdata_o(rx_wdata),
    .rx_wen_o(rx_wen), .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
    .eng_op_o(eng_op), .eng_start_o(eng_start), .eng_ack_o(eng_ack),
    .eng_wdata_o(eng_wdata), .eng_done_i(eng_done), .eng_rdata_i(eng_rdata),
    .eng_nack_i(eng_nack), .eng_arb_lost_i(eng_arb), .busy_o(busy), .halted_o(halted)
  );

  always #5 clk = ~clk;

  assign eng_ready = eng_valid;
  assign eng_rdata = resp_rdata;
  assign eng_nack  = resp_nack;
  assign eng_arb   = resp_arb;

  always @(posedge clk) tx_rdata <= txmem[tx_raddr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (eng_valid) valid_cyc <= valid_cyc + 1;
      if (eng_valid && eng_ready) begin
        acc_cnt    <= acc_cnt + 1;
        last_op    <= eng_op;
        last_start <= eng_start;
        last_ack   <= eng_ack;
        last_wdata <= eng_wdata;
        eng_done   <= !hold_done;
      end
    end
  end

  always @(posedge clk) begin
    if (rx_wen) begin
      wr_count <= wr_count + 1;
      log_addr.push_back(rx_waddr);
      log_data.push_back(rx_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; tx_wp = '0; rx_rp = '0;
    resp_rdata = '0; resp_nack = 1'b0; resp_arb = 1'b0; hold_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_wr(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_count >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_txrp(input logic [7:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_rp == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; tx_wp = 8'h03; rx_rp = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (tx_rp !== 8'h00) begin n_fail++; $display("FAIL reset_tx_rp: got %h expected 00", tx_rp); end
    n_checks++; if (rx_wp !== 8'h00) begin n_fail++; $display("FAIL reset_rx_wp: got %h expected 00", rx_wp); end
    n_checks++; if ({busy, halted, rx_wen, eng_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, halted, rx_wen, eng_valid}); end
    n_checks++; if ({eng_op, eng_start, eng_ack, eng_wdata} !== 12'h000) begin n_fail++; $display("FAIL reset_cmd: got %h expected 000", {eng_op, eng_start, eng_ack, eng_wdata}); end
    n_checks++; if (rx_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_rx_wdata: got %h expected 00000000", rx_wdata); end
    enable = 1'b0; tx_wp = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    int w0, a0, lat;
    bit ok;
    do_reset();
    w0 = wr_count; a0 = acc_cnt; lat = 0;
    txmem[0] = 32'h0000_045A;
    enable = 1'b1; tx_wp = 8'h01;
    // IDLE cycle is cycle 1; rx_wen_o must be high after the 5th edge (cycle 6).
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rx_wen && lat == 0) lat = k;
      if (lat != 0) break;
    end
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL write_latency: got %0d edges expected 5", lat); end
    wait_wr(w0 + 1, 10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL write_timeout: got no rx write expected 1"); end
    else begin
      n_checks++; if (log_addr[w0] !== 8'h00) begin n_fail++; $display("FAIL write_rx_addr: got %h expected 00", log_addr[w0]); end
      n_checks++; if (log_data[w0] !== 32'h0) begin n_fail++; $display("FAIL write_result: got %h expected 00000000", log_data[w0]); end
    end
    n_checks++; if (tx_rp !== 8'h01 || rx_wp !== 8'h01) begin n_fail++; $display("FAIL write_ptrs: got tx_rp=%h rx_wp=%h expected 01/01", tx_rp, rx_wp); end
    n_checks++; if (acc_cnt != a0 + 1) begin n_fail++; $display("FAIL write_eng_count: got %0d expected %0d", acc_cnt - a0, 1); end
    n_checks++; if ({last_op, last_start, last_ack, last_wdata} !== {2'd0, 1'b1, 1'b0, 8'h5A}) begin n_fail++; $display("FAIL write_eng_fields: got op=%0d start=%b ack=%b wdata=%h expected 0/1/0/5a", last_op, last_start, last_ack, last_wdata); end
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || wr_count != w0 + 1) begin n_fail++; $display("FAIL write_idle_after: got busy=%b writes=%0d expected 0/1", busy, wr_count - w0); end
  endtask

  task automatic test_read();
    int w0;
    bit ok;
    do_reset();
    w0 = wr_count;
    txmem[0] = 32'h0000_0900;
    resp_rdata = 8'hC3;
    enable = 1'b1; tx_wp = 8'h01;
    wait_wr(w0 + 1, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL read_timeout: got no rx write expected 1"); end
    else begin
      n_checks++; if (log_data[w0] !== 32'h0000_00C3) begin n_fail++; $display("FAIL read_result: got %h expected 000000c3", log_data[w0]); end
    end
    n_checks++; if ({last_op, last_start, last_ack} !== {2'd1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL read_eng_fields: got op=%0d start=%b ack=%b expected 1/0/1", last_op, last_start, last_ack); end
    resp_rdata = '0;
  endtask

  task automatic test_rx_full();
    int w0;
    bit ok;
    do_reset();
    for (int i = 0; i < 256; i++) txmem[i] = 32'h0000_045A;
    w0 = wr_count;
    enable = 1'b1; tx_wp = 8'h04;
    wait_wr(w0 + 4, 60, ok);
    n_checks++; if (!ok || rx_wp !== 8'h04) begin n_fail++; $display("FAIL full_prefill: got ok=%b rx_wp=%h expected 1/04", ok, rx_wp); end
    rx_rp = 8'h05; tx_wp = 8'h05;
    repeat (15) @(negedge clk);
    n_checks++; if (wr_count != w0 + 4 || rx_wen !== 1'b0) begin n_fail++; $display("FAIL full_stall_write: got writes=%0d wen=%b expected 4/0", wr_count - w0, rx_wen); end
    n_checks++; if (busy !== 1'b1 || rx_wp !== 8'h04 || tx_rp !== 8'h04) begin n_fail++; $display("FAIL full_stall_state: got busy=%b rx_wp=%h tx_rp=%h expected 1/04/04", busy, rx_wp, tx_rp); end
    rx_rp = 8'h06;
    wait_wr(w0 + 5, 10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_release_timeout: got no rx write expected 1"); end
    else begin
      n_checks++; if (log_addr[w0 + 4] !== 8'h04 || log_data[w0 + 4] !== 32'h0004_0000) begin n_fail++; $display("FAIL full_release_write: got addr=%h data=%h expected 04/00040000", log_addr[w0 + 4], log_data[w0 + 4]); end
    end
    n_checks++; if (rx_wp !== 8'h05 || tx_rp !== 8'h05) begin n_fail++; $display("FAIL full_release_ptrs: got rx_wp=%h tx_rp=%h expected 05/05", rx_wp, tx_rp); end
  endtask

  task automatic test_wrap();
    int w0;
    bit ok;
    do_reset();
    enable = 1'b1; tx_wp = 8'h80;
    wait_txrp(8'h80, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_advance_80: got tx_rp=%h expected 80", tx_rp); end
    rx_rp = 8'h80; tx_wp = 8'hFF;
    wait_txrp(8'hFF, 1500, ok);
    n_checks++; if (!ok || rx_wp !== 8'hFF) begin n_fail++; $display("FAIL wrap_advance_ff: got tx_rp=%h rx_wp=%h expected ff/ff", tx_rp, rx_wp); end
    w0 = wr_count;
    rx_rp = 8'hC0; tx_wp = 8'h01;
    wait_wr(w0 + 2, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got %0d writes expected 2", wr_count - w0); end
    else begin
      n_checks++; if (log_data[w0] !== 32'h00FF_0000 || log_addr[w0] !== 8'hFF) begin n_fail++; $display("FAIL wrap_first: got addr=%h data=%h expected ff/00ff0000", log_addr[w0], log_data[w0]); end
      n_checks++; if (log_data[w0 + 1] !== 32'h0000_0000 || log_addr[w0 + 1] !== 8'h00) begin n_fail++; $display("FAIL wrap_second: got addr=%h data=%h expected 00/00000000", log_addr[w0 + 1], log_data[w0 + 1]); end
    end
    n_checks++; if (tx_rp !== 8'h01 || rx_wp !== 8'h01) begin n_fail++; $display("FAIL wrap_ptrs: got tx_rp=%h rx_wp=%h expected 01/01", tx_rp, rx_wp); end
  endtask

  task automatic test_arb_halt();
    int w0, a1;
    bit ok;
    do_reset();
    w0 = wr_count;
    resp_arb = 1'b1;
    enable = 1'b1; tx_wp = 8'h02;
    wait_wr(w0 + 1, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL arb_timeout: got no rx write expected 1"); end
    else begin
      n_checks++; if (log_data[w0] !== 32'h0000_0200) begin n_fail++; $display("FAIL arb_result: got %h expected 00000200", log_data[w0]); end
    end
    resp_arb = 1'b0; resp_nack = 1'b1;
    a1 = acc_cnt;
    repeat (10) @(negedge clk);
    n_checks++; if (halted !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL arb_halted: got halted=%b busy=%b expected 1/1", halted, busy); end
    n_checks++; if (tx_rp !== 8'h01 || acc_cnt != a1 || wr_count != w0 + 1) begin n_fail++; $display("FAIL arb_no_fetch: got tx_rp=%h eng=%0d writes=%0d expected 01/0/1", tx_rp, acc_cnt - a1, wr_count - w0); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++; if (halted !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arb_release: got halted=%b busy=%b expected 0/0", halted, busy); end
    enable = 1'b1;
    wait_wr(w0 + 2, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL arb_resume_timeout: got no rx write expected 1"); end
    else begin
      n_checks++; if (log_data[w0 + 1] !== 32'h0001_0100) begin n_fail++; $display("FAIL arb_resume_result: got %h expected 00010100", log_data[w0 + 1]); end
    end
    n_checks++; if (halted !== 1'b0 || rx_wp !== 8'h02) begin n_fail++; $display("FAIL nack_no_halt: got halted=%b rx_wp=%h expected 0/02", halted, rx_wp); end
    resp_nack = 1'b0;
  endtask

  task automatic test_bad_op_reset();
    int w0, a0, v0;
    bit ok;
    do_reset();
    w0 = wr_count; a0 = acc_cnt; v0 = valid_cyc;
    txmem[0] = 32'h0000_0300;
    enable = 1'b1; tx_wp = 8'h01;
    wait_wr(w0 + 1, 30, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL badop_timeout: got no rx write expected 1"); end
    else begin
      n_checks++; if (log_data[w0] !== 32'h0000_0400) begin n_fail++; $display("FAIL badop_result: got %h expected 00000400", log_data[w0]); end
    end
    n_checks++; if (acc_cnt != a0 || valid_cyc != v0) begin n_fail++; $display("FAIL badop_no_engine: got eng=%0d valid_cycles=%0d expected 0/0", acc_cnt - a0, valid_cyc - v0); end
    hold_done = 1'b1;
    txmem[1] = 32'h0000_045A;
    tx_wp = 8'h02;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt == a0 + 1) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (!ok || busy !== 1'b1) begin n_fail++; $display("FAIL wait_reached: got accepted=%b busy=%b expected 1/1", ok, busy); end
    rst_n = 1'b0; enable = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_rp !== 8'h00 || rx_wp !== 8'h00 || busy !== 1'b0 || rx_wen !== 1'b0) begin n_fail++; $display("FAIL midcmd_reset: got tx_rp=%h rx_wp=%h busy=%b wen=%b expected 00/00/0/0", tx_rp, rx_wp, busy, rx_wen); end
    rst_n = 1'b1; hold_done = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (wr_count != w0 + 1 || busy !== 1'b0) begin n_fail++; $display("FAIL midcmd_dropped: got writes=%0d busy=%b expected 1/0", wr_count - w0, busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) txmem[i] = 32'h0000_045A;
    test_reset();
    test_write();
    test_read();
    test_rx_full();
    test_wrap();
    test_arb_halt();
    test_bad_op_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
